// File: rtl/dm_pkg.sv
// Shared constants for the debug-module system-bus arbiter slice.
package dm_pkg;

    // Value driven on err_o when a bus response arrives with nothing outstanding.
    localparam logic ErrUnexpectedRsp = 1'b1;

endpackage

// File: rtl/dm_sbus_id_fifo.sv
// In-order FIFO of requester indices, one entry per accepted bus transaction.
module dm_sbus_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [CntW-1:0]  cnt_q;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (32'(ptr) == Depth - 1) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full     = (cnt_q == CntW'(Depth));
    assign empty    = (cnt_q == '0);
    assign pop_data = mem_q[rptr_q];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= next_ptr(wptr_q);
            if (pop)  rptr_q <= next_ptr(rptr_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage holds no control state; an empty FIFO never exposes it.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= push_data;
    end

endmodule

// File: rtl/dm_sbus_arbiter.sv
// Round-robin arbiter sharing one system-bus master port between debug-side
// requesters; responses are routed back in order through an ID FIFO.
module dm_sbus_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned BusWidth       = 32,
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         dmactive_i,
    input  logic [NumReq-1:0]            req_i,
    input  logic [NumReq*BusWidth-1:0]   add_i,
    input  logic [NumReq-1:0]            we_i,
    input  logic [NumReq*BusWidth-1:0]   wdata_i,
    input  logic [NumReq*BusWidth/8-1:0] be_i,
    output logic [NumReq-1:0]            gnt_o,
    output logic [NumReq-1:0]            r_valid_o,
    output logic [BusWidth-1:0]          r_rdata_o,
    output logic                         master_req_o,
    output logic [BusWidth-1:0]          master_add_o,
    output logic                         master_we_o,
    output logic [BusWidth-1:0]          master_wdata_o,
    output logic [BusWidth/8-1:0]        master_be_o,
    input  logic                         master_gnt_i,
    input  logic                         master_r_valid_i,
    input  logic [BusWidth-1:0]          master_r_rdata_i,
    output logic                         err_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned BeW  = BusWidth / 8;

    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] sel_q;
    logic            lock_q;
    logic [IdxW-1:0] sel;
    logic            lock_hold;
    logic            issue;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IdxW-1:0] head;

    // First asserted request at or after ptr, wrapping modulo NumReq.
    function automatic logic [IdxW-1:0] rr_select(input logic [NumReq-1:0] req,
                                                   input logic [IdxW-1:0]   ptr);
        logic [IdxW-1:0] pick;
        logic            found;
        int unsigned     idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = (32'(ptr) + i) % NumReq;
            if (!found && req[idx[IdxW-1:0]]) begin
                pick  = idx[IdxW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // A stalled request keeps the bus pinned to the same requester unless it withdraws.
    assign lock_hold = lock_q & req_i[sel_q];
    assign sel       = lock_hold ? sel_q : rr_select(req_i, rr_q);
    assign issue     = (|req_i) & dmactive_i & ~fifo_full;
    assign push      = issue & master_gnt_i;
    assign pop       = master_r_valid_i & ~fifo_empty;

    always_comb begin
        master_req_o   = issue;
        master_add_o   = '0;
        master_we_o    = 1'b0;
        master_wdata_o = '0;
        master_be_o    = '0;
        gnt_o          = '0;
        r_valid_o      = '0;
        if (issue) begin
            master_add_o   = add_i[32'(sel)*BusWidth +: BusWidth];
            master_we_o    = we_i[sel];
            master_wdata_o = wdata_i[32'(sel)*BusWidth +: BusWidth];
            master_be_o    = be_i[32'(sel)*BeW +: BeW];
        end
        if (push) gnt_o[sel] = 1'b1;
        if (pop)  r_valid_o[head] = 1'b1;
    end

    assign r_rdata_o = master_r_rdata_i;
    assign err_o     = (master_r_valid_i & fifo_empty) ? ErrUnexpectedRsp : 1'b0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            sel_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            lock_q <= issue & ~master_gnt_i;
            if (issue & ~master_gnt_i) sel_q <= sel;
            if (push) rr_q <= (32'(sel) == NumReq - 1) ? '0 : sel + IdxW'(1);
        end
    end

    dm_sbus_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) i_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (push),
        .push_data (sel),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/dm_sbus_arbiter.md
Name: dm_sbus_arbiter

Overview:
- Shares one system-bus master port (req/gnt/r_valid protocol) between NumReq debug-side requesters, e.g. the SBA engine and a program-buffer or abstract-command memory accessor.
- Arbitration is round-robin. Up to MaxOutstanding transactions may be in flight.
- Each response is routed back to its issuer through an in-order ID FIFO.
- Sits between the requesters and the SoC bus adapter inside the debug module.

Parameters:
- BusWidth, 32, address/data width; byte-enable width is BusWidth/8
- NumReq, 2, number of requesters (>=2)
- MaxOutstanding, 2, accepted-but-unanswered transactions (>=1, power of two)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- dmactive_i  in  1  low blocks new grants
- req_i  in  NumReq  per-requester request
- add_i  in  NumReq*BusWidth  addresses, requester k at [k*BusWidth +: BusWidth]
- we_i  in  NumReq  write enables
- wdata_i  in  NumReq*BusWidth  write data
- be_i  in  NumReq*BusWidth/8  byte enables
- gnt_o  in/out: out  NumReq  one-hot grant
- r_valid_o  out  NumReq  one-hot response valid
- r_rdata_o  out  BusWidth  response data, broadcast to all requesters
- master_req_o  out  1  bus request
- master_add_o  out  BusWidth  bus address
- master_we_o  out  1  bus write enable
- master_wdata_o  out  BusWidth  bus write data
- master_be_o  out  BusWidth/8  bus byte enables
- master_gnt_i  in  1  bus grant
- master_r_valid_i  in  1  bus response valid
- master_r_rdata_i  in  BusWidth  bus response data
- err_o  out  1  one-cycle pulse on an unexpected response

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low: on a clk_i edge with rst_ni=0, every register clears (rr pointer=0, lock=0, FIFO empty, counts=0).
- Outputs in reset and idle: all outputs 0, except r_rdata_o, which passes master_r_rdata_i through.
- Selection: sel = first asserted req_i at or after rr pointer, modulo NumReq.
- Lock: if master_req_o=1 and master_gnt_i=0, sel_q and lock_q are registered. The next cycle must present the same requester. Lock clears on master_gnt_i, or if the locked requester drops req_i (protocol violation tolerated: drop request, no err).
- Issue condition: issue = any req_i & dmactive_i & !fifo_full.
  - master_req_o = issue.
  - master_add_o, master_we_o, master_wdata_o and master_be_o are muxed combinationally from sel.
  - All are 0 when not issuing.
- Grant: gnt_o[sel] = master_gnt_i & issue (combinational; zero latency from master_gnt_i).
- On a grant:
  - push sel into the ID FIFO;
  - rr pointer <= sel+1, wrapping NumReq-1 -> 0.
- Response:
  - on master_r_valid_i with FIFO non-empty, r_valid_o[fifo_head]=1 and the FIFO pops, same cycle;
  - with FIFO empty, r_valid_o=0 and err_o=1 for one cycle.
- Responses arrive in order and reads and writes both produce one r_valid, so at most one grant and one response per cycle.
- Simultaneous grant and response in one cycle: push and pop together, count unchanged. Allowed when the FIFO is full; in that case issue is already blocked that cycle because the full test uses the registered count.
- Minimum response latency: master_r_valid_i is earliest one cycle after master_gnt_i. A same-cycle response is not supported and counts as err_o.
- dmactive_i low: no new grants; the lock is released. Outstanding responses are still routed and popped normally.
- Reset mid-transaction: FIFO cleared. A late master_r_valid_i after reset produces err_o, never r_valid_o.

Decomposition:
- dm_pkg holds only the err code constant; width helper IdxW = max(1,$clog2(NumReq)) is a localparam.
- Sub-module dm_sbus_id_fifo:
  - parameters Depth=MaxOutstanding, Width=IdxW;
  - ports push/pop/data/full/empty;
  - synchronous active-low reset.
- Round-robin select is an in-module function.

Test Plan:
1. Requester 0 read, addr 0x1000, master_gnt_i same cycle, r_valid 2 cycles later with rdata 0xDEADBEEF -> gnt_o=01, then r_valid_o=01, r_rdata_o=0xDEADBEEF.
2. Both requesters held continuously, gnt always 1, responses after 1 cycle -> grants alternate 01,10,01,10; responses are routed to the matching requester.
3. Requester 1 write 0x2000/0x55AA, master_gnt_i low 3 cycles while requester 0 rises -> master_add_o stays 0x2000 until grant, and requester 1 is granted first.
4. MaxOutstanding=2, three back-to-back grants wanted with no response -> third request is held (master_req_o=0) until the first r_valid. Responses return to issuers 0,1,0 in order.
5. master_r_valid_i pulse with empty FIFO -> err_o=1 for one cycle, r_valid_o=00.
6. rst_ni=0 for one edge with 2 outstanding, then r_valid -> all outputs 0 after the edge, and the late response yields err_o=1.
